// File: rtl/generic_n_way_wb_cache.sv
// generic_n_way_wb_cache
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// One outstanding request; one data word per line. Misses go through a
// WB (dirty victim writeback) / FILL (line fetch) sequence over a req/ack
// memory handshake, then RESP.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (accepted only in IDLE)
//   req_we/req_addr/req_wdata request fields (index = low IDX_W address bits)
//   rsp_valid/rsp_rdata/rsp_hit one-cycle response pulse (hit=1 on hit path)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request, held to ack
//   mem_ack/mem_rdata        memory completion and fill data
//   hit_cnt/miss_cnt/wb_cnt  saturating statistics (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN
module generic_n_way_wb_cache #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int ENTRIES    = 8,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef CACHE_STATS_EN
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [31:0]           wb_cnt,
`endif
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam int ENT_W = IDX_W + AGE_W;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;
    state_t r_state, w_state_next;

    // Latched request
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [AGE_W-1:0]      r_vict;

    // Line storage; entry number is {set index, way}
    logic [DATA_WIDTH-1:0] r_data [ENTRIES];
    logic [TAG_W-1:0]      r_tag  [ENTRIES];
    logic [AGE_W-1:0]      r_age  [ENTRIES];
    logic [ENTRIES-1:0]    r_valid;
    logic [ENTRIES-1:0]    r_dirty;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [ENT_W-1:0] w_ent [WAYS];
    logic [WAYS-1:0]  w_way_hit;
    logic [WAYS-1:0]  w_way_valid;
    logic             w_hit;
    logic [AGE_W-1:0] w_hit_way;
    logic [AGE_W-1:0] w_vict;
    logic             w_vict_found;
    logic             w_vict_dirty;
    logic [ENT_W-1:0] w_hit_ent;
    logic [ENT_W-1:0] w_vict_ent;
    logic [ENT_W-1:0] w_rvict_ent;
    logic [ENT_W-1:0] w_lru_ent;
    logic             w_lru_en;
    logic [AGE_W-1:0] w_lru_way;
    logic             w_ack;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_WIDTH-1:IDX_W];
    assign w_ack = mem_ack && mem_req;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_ent[gi]       = {w_idx, AGE_W'(gi)};
            assign w_way_valid[gi] = r_valid[w_ent[gi]];
            assign w_way_hit[gi]   = w_way_valid[gi] && (r_tag[w_ent[gi]] == w_tag);
        end
    endgenerate

    assign w_hit        = |w_way_hit;
    assign w_hit_ent    = {w_idx, w_hit_way};
    assign w_vict_ent   = {w_idx, w_vict};
    assign w_rvict_ent  = {w_idx, r_vict};
    assign w_lru_ent    = {w_idx, w_lru_way};
    assign w_vict_dirty = r_valid[w_vict_ent] && r_dirty[w_vict_ent];

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_way_hit[w]) w_hit_way = AGE_W'(w);
    end

    // Victim: lowest-index invalid way, else the oldest way (age WAYS-1)
    always_comb begin
        w_vict       = '0;
        w_vict_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_way_valid[w] && !w_vict_found) begin
                w_vict       = AGE_W'(w);
                w_vict_found = 1'b1;
            end
        end
        if (!w_vict_found)
            for (int w = 0; w < WAYS; w++)
                if (r_age[w_ent[w]] == AGE_W'(WAYS - 1)) w_vict = AGE_W'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and combinational response outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_hit      = 1'b0;
        rsp_rdata    = '0;
        w_lru_en     = 1'b0;
        w_lru_way    = w_hit_way;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    rsp_valid    = 1'b1;
                    rsp_hit      = 1'b1;
                    rsp_rdata    = r_we ? r_wdata : r_data[w_hit_ent];
                    w_lru_en     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_vict_dirty ? S_WB : S_FILL;
                end
            end
            S_WB:   if (w_ack) w_state_next = S_FILL;
            S_FILL: if (w_ack) w_state_next = S_RESP;
            S_RESP: begin
                rsp_valid    = 1'b1;
                rsp_rdata    = r_we ? r_wdata : r_data[w_rvict_ent];
                w_lru_en     = 1'b1;
                w_lru_way    = r_vict;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control state: latched request, valid/dirty/age, memory request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_vict    <= '0;
            r_valid   <= '0;
            r_dirty   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int e = 0; e < ENTRIES; e++) r_age[e] <= AGE_W'(e % WAYS);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) r_dirty[w_hit_ent] <= 1'b1;
                    end else begin
                        r_vict  <= w_vict;
                        mem_req <= 1'b1;
                        if (w_vict_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {r_tag[w_vict_ent], w_idx};
                            mem_wdata <= r_data[w_vict_ent];
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= r_addr;
                        end
                    end
                end
                S_WB: begin
                    // Keep mem_req high and retarget straight at the fill
                    if (w_ack) begin
                        r_valid[w_rvict_ent] <= 1'b0;
                        r_dirty[w_rvict_ent] <= 1'b0;
                        mem_we               <= 1'b0;
                        mem_addr             <= r_addr;
                    end
                end
                S_FILL: begin
                    if (w_ack) begin
                        mem_req              <= 1'b0;
                        r_valid[w_rvict_ent] <= 1'b1;
                        r_dirty[w_rvict_ent] <= 1'b0;
                    end
                end
                S_RESP: if (r_we) r_dirty[w_rvict_ent] <= 1'b1;
                default: ;
            endcase

            // True LRU: accessed way becomes youngest, younger ways age by one
            if (w_lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == w_lru_way)
                        r_age[w_ent[w]] <= '0;
                    else if (r_age[w_ent[w]] < r_age[w_lru_ent])
                        r_age[w_ent[w]] <= r_age[w_ent[w]] + AGE_W'(1);
                end
            end
        end
    end

    // Data/tag arrays carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        case (r_state)
            S_LOOKUP: if (w_hit && r_we) r_data[w_hit_ent] <= r_wdata;
            S_FILL: begin
                if (w_ack) begin
                    r_data[w_rvict_ent] <= mem_rdata;
                    r_tag[w_rvict_ent]  <= w_tag;
                end
            end
            S_RESP: if (r_we) r_data[w_rvict_ent] <= r_wdata;
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (r_state == S_LOOKUP && w_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (r_state == S_LOOKUP && !w_hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
            if (r_state == S_LOOKUP && w_state_next == S_WB && wb_cnt != '1)
                wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_generic_n_way_wb_cache.sv
// Bench for generic_n_way_wb_cache (default parameters: 4 sets x 2 ways).
// Driver pushes expected responses and expected memory transactions into
// queues; a response monitor and a memory responder pop and compare.
module tb_generic_n_way_wb_cache;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_we, req_ready;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_hit;
    logic [7:0] rsp_rdata;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
    logic [31:0] h0, m0, w0;
`endif

    always #5 clk = ~clk;

    generic_n_way_wb_cache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef CACHE_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
`endif
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [7:0] rdata; logic hit; } rsp_exp_t;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } mem_exp_t;

    rsp_exp_t   exp_q[$];
    mem_exp_t   mem_q[$];
    rsp_exp_t   mon_e;
    mem_exp_t   mem_e;
    logic [7:0] mem_model [256];

    int checks = 0;
    int fails  = 0;
    int cycle_cnt = 0;
    int acc_cyc = 0;
    int rsp_seen = 0;
    int issued = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    bit mem_busy = 0;

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Response monitor
    initial forever begin
        @(negedge clk);
        if (!rst && rsp_valid) begin
            $display("rsp: rdata=%02h hit=%0b cycle=%0d", rsp_rdata, rsp_hit, cycle_cnt);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got rdata=%02h hit=%0b, required no response",
                         rsp_rdata, rsp_hit);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_rdata !== mon_e.rdata) begin
                    fails++;
                    $display("FAIL rsp_rdata: got %02h, required %02h", rsp_rdata, mon_e.rdata);
                end
                checks++;
                if (rsp_hit !== mon_e.hit) begin
                    fails++;
                    $display("FAIL rsp_hit: got %0b, required %0b", rsp_hit, mon_e.hit);
                end
                if (mon_e.hit) begin
                    checks++;
                    if (cycle_cnt - acc_cyc != 1) begin
                        fails++;
                        $display("FAIL hit_latency: got %0d, required 1", cycle_cnt - acc_cyc);
                    end
                end
            end
            rsp_seen++;
        end
    end

    // Memory responder: checks each new request, acks after ack_delay cycles
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack  = 1'b0;
                mem_busy = 0;
            end else if (!mem_req || rst) begin
                mem_busy = 0;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    ack_cnt  = 0;
                    $display("mem: we=%0b addr=%02h wdata=%02h", mem_we, mem_addr, mem_wdata);
                    checks++;
                    if (mem_q.size() == 0) begin
                        fails++;
                        $display("FAIL mem_unexpected: got we=%0b addr=%02h, required no request",
                                 mem_we, mem_addr);
                    end else begin
                        mem_e = mem_q.pop_front();
                        if (mem_we !== mem_e.we || mem_addr !== mem_e.addr ||
                            (mem_e.we && mem_wdata !== mem_e.wdata)) begin
                            fails++;
                            $display("FAIL mem_req: got we=%0b addr=%02h wdata=%02h, required we=%0b addr=%02h wdata=%02h",
                                     mem_we, mem_addr, mem_wdata, mem_e.we, mem_e.addr, mem_e.wdata);
                        end
                    end
                end
                if (ack_cnt >= ack_delay) begin
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    mem_rdata = mem_model[mem_addr];
                    mem_ack   = 1'b1;
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    task automatic exp_mem(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.wdata = wdata;
        mem_q.push_back(m);
    endtask

    task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cycle_cnt;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_hit, input int hold);
        rsp_exp_t e;
        int n;
        e.rdata = exp_rdata; e.hit = exp_hit;
        exp_q.push_back(e);
        issued++;
        $display("req: we=%0b addr=%02h wdata=%02h", we, addr, wdata);
        send(we, addr, wdata);
        if (hold > 0) begin
            // A competing request held while busy must not be accepted
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h99; req_wdata = 8'h00;
            repeat (hold) @(negedge clk);
            req_valid = 1'b0;
        end
        n = 0;
        while (rsp_seen < issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_seen < issued) begin
            fails++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_seen, issued);
            rsp_seen = issued;
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hC3;
        mem_model[8'hAA] = 8'h5C; mem_model[8'h02] = 8'h3C; mem_model[8'h06] = 8'h66;
        mem_model[8'h13] = 8'h31; mem_model[8'h01] = 8'hA1; mem_model[8'h05] = 8'hA5;
        mem_model[8'h09] = 8'hA9; mem_model[8'hFF] = 8'hEE; mem_model[8'h30] = 8'h03;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_hit",   32'(rsp_hit),   32'h0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("reset_mem_req",   32'(mem_req),   32'h0);
        chk("reset_mem_we",    32'(mem_we),    32'h0);
        chk("reset_mem_addr",  32'(mem_addr),  32'h0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;

        // Fill then hit
        exp_mem(0, 8'hAA, 8'h00); do_req(0, 8'hAA, 8'h00, 8'h5C, 0, 0);
        do_req(0, 8'hAA, 8'h00, 8'h5C, 1, 0);
`ifdef CACHE_STATS_EN
        h0 = hit_cnt; m0 = miss_cnt; w0 = wb_cnt;
`endif
        // Write hit, second way fill, dirty LRU eviction
        do_req(1, 8'hAA, 8'h11, 8'h11, 1, 0);
        exp_mem(0, 8'h02, 8'h00); do_req(0, 8'h02, 8'h00, 8'h3C, 0, 0);
        exp_mem(1, 8'hAA, 8'h11); exp_mem(0, 8'h06, 8'h00);
        do_req(0, 8'h06, 8'h00, 8'h66, 0, 0);
`ifdef CACHE_STATS_EN
        chk("stats_hit",  hit_cnt - h0,  32'd1);
        chk("stats_miss", miss_cnt - m0, 32'd2);
        chk("stats_wb",   wb_cnt - w0,   32'd1);
`endif
        // Write miss with ack in the same cycle mem_req rises
        ack_delay = 0;
        exp_mem(0, 8'h13, 8'h00); do_req(1, 8'h13, 8'h77, 8'h77, 0, 0);
        ack_delay = 1;
        do_req(0, 8'h13, 8'h00, 8'h77, 1, 0);

        // Clean eviction by LRU
        exp_mem(0, 8'h01, 8'h00); do_req(0, 8'h01, 8'h00, 8'hA1, 0, 0);
        ack_delay = 2;
        exp_mem(0, 8'h05, 8'h00); do_req(0, 8'h05, 8'h00, 8'hA5, 0, 3);
        ack_delay = 1;
        do_req(0, 8'h01, 8'h00, 8'hA1, 1, 0);
        exp_mem(0, 8'h09, 8'h00); do_req(0, 8'h09, 8'h00, 8'hA9, 0, 0);
        do_req(0, 8'h01, 8'h00, 8'hA1, 1, 0);
        exp_mem(0, 8'h05, 8'h00); do_req(0, 8'h05, 8'h00, 8'hA5, 0, 0);

        // All-ones index and tag
        exp_mem(0, 8'hFF, 8'h00); do_req(0, 8'hFF, 8'h00, 8'hEE, 0, 0);
        do_req(0, 8'hFF, 8'h00, 8'hEE, 1, 0);

        // Reset in FILL with ack withheld; no response for the aborted request
        ack_delay = 1000;
        exp_mem(0, 8'h30, 8'h00);
        $display("req: we=0 addr=30 (aborted by reset)");
        send(0, 8'h30, 8'h00);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_mem_req_seen", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_req",   32'(mem_req),   32'h0);
        chk("abort_req_ready", 32'(req_ready), 32'h1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        ack_delay = 1;
        repeat (3) @(negedge clk);
        // Lines are invalid after reset; written-back value comes from memory
        exp_mem(0, 8'hAA, 8'h00); do_req(0, 8'hAA, 8'h00, 8'h11, 0, 0);
        exp_mem(0, 8'h13, 8'h00); do_req(0, 8'h13, 8'h00, 8'h31, 0, 0);

        repeat (5) @(negedge clk);
        chk("rsp_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
